// File: rtl/alu_op_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_op_issuer : request FIFO + issue register feeding a gated ALU, with a
//                 one-entry result slot and valid/ready output.  Rev 1.0
// ----------------------------------------------------------------------------
module alu_op_issuer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [3:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_op,
  output logic                     alu_en,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [3:0]               out_op,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 * WIDTH + 4 + TAG_W;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_op_q, out_op_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             push, pop, advance, fifo_nonempty, fire;
  logic [WIDTH-1:0] head_a, head_b;
  logic [3:0]       head_op;
  logic [TAG_W-1:0] head_tag;

  assign {head_a, head_b, head_op, head_tag} = mem_q[rd_ptr_q];

  always_comb begin
    fifo_nonempty = (level_q != '0);
    advance       = !out_valid_q || out_ready;
    fire          = s1_valid_q && advance && !flush;
    push          = in_valid && (level_q != DEPTH_L) && !flush;
    // Loading is blocked during flush so the ALU pins never move on a flush.
    pop           = fifo_nonempty && (!s1_valid_q || fire) && !flush;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    s1_valid_d  = s1_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    s1_tag_d    = s1_tag_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_tag_d   = out_tag_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);

      if (pop) begin
        s1_valid_d = 1'b1;
        alu_a_d    = head_a;
        alu_b_d    = head_b;
        alu_op_d   = head_op;
        s1_tag_d   = head_tag;
      end else if (fire) begin
        s1_valid_d = 1'b0;
      end

      if (fire) begin
        out_valid_d = 1'b1;
        out_op_d    = alu_op_q;
        out_tag_d   = s1_tag_q;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by level/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b, in_op, in_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      s1_valid_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      s1_valid_q  <= s1_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready  = (level_q != DEPTH_L);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_en    = fire;
  assign out_valid = out_valid_q;
  assign out_data  = alu_result;
  assign out_op    = out_op_q;
  assign out_tag   = out_tag_q;
  assign level     = level_q;
  assign idle      = !fifo_nonempty && !s1_valid_q && !out_valid_q;

endmodule
`default_nettype wire
